// File: rtl/encoder_4to2_event.sv
// encoder_4to2_event
//   Event-capturing 4-to-2 priority encoder. Four asynchronous lines are
//   synchronised and their rising edges are queued as pending events. The
//   events are then issued one at a time as a 2-bit code.
//
//   Handshake: valid=1 means code_out holds an unacknowledged event. The event
//   is consumed on the rising clk edge where valid=1 and ack=1. After that
//   edge valid drops for at least one cycle before the next code is issued.
//   ack is ignored while valid=0.
//
//   The FSM state is visible on valid: valid=1 exactly when the FSM is in HOLD.
//
// Parameters
//   SYNC_STAGES : flops per input synchroniser chain (2..4)
//   HIGH_FIRST  : 1 = bit 3 wins priority, 0 = bit 0 wins priority
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   in[3:0]  : asynchronous event lines
//   ack      : downstream accepts current code
//   code_out : encoded index of the issued event
//   valid    : code_out holds an unacknowledged event
//   multi    : two or more events pending, including the issued one
//   overflow : one-cycle pulse; a duplicate edge was dropped
module encoder_4to2_event #(
    parameter int SYNC_STAGES = 2,
    parameter bit HIGH_FIRST  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in,
    input  logic       ack,
    output logic [1:0] code_out,
    output logic       valid,
    output logic       multi,
    output logic       overflow
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t     state;
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] s;
    logic [3:0] prev;
    logic [3:0] rise;
    logic [3:0] pending;
    logic [3:0] clr;
    logic [3:0] pending_next;

    // Highest-priority set bit of a pending vector.
    function automatic logic [1:0] prio(input logic [3:0] p);
        logic [1:0] r;
        r = 2'd0;
        if (HIGH_FIRST) begin
            if (p[3])      r = 2'd3;
            else if (p[2]) r = 2'd2;
            else if (p[1]) r = 2'd1;
            else           r = 2'd0;
        end else begin
            if (p[0])      r = 2'd0;
            else if (p[1]) r = 2'd1;
            else if (p[2]) r = 2'd2;
            else           r = 2'd3;
        end
        return r;
    endfunction

    // Input synchronisers, one chain of SYNC_STAGES flops per line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= 4'b0000;
        end else begin
            sync_q[0] <= in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    // prev resets to 0, so a line held high through reset is seen as one rise.
    assign rise = s & ~prev;

    always_comb begin
        clr = 4'b0000;
        if (state == HOLD && ack) clr[code_out] = 1'b1;
    end

    // Set beats clear when a new rise lands on the acknowledged bit.
    assign pending_next = (pending & ~clr) | rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev     <= 4'b0000;
            pending  <= 4'b0000;
            multi    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            prev     <= s;
            pending  <= pending_next;
            multi    <= ($countones(pending_next) >= 2);
            overflow <= |(rise & pending & ~clr);
        end
    end

    // Issue FSM. Priority is evaluated from the registered pending vector on
    // every IDLE cycle, so a higher-priority arrival during HOLD goes next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            code_out <= 2'b00;
            valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending != 4'b0000) begin
                        code_out <= prio(pending);
                        valid    <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (ack) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_4to2_event.sv
module tb_encoder_4to2_event;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in  = 4'b0000;
    logic       ack = 1'b0;

    logic [1:0] code_h, code_l;
    logic       valid_h, valid_l;
    logic       multi_h, multi_l;
    logic       ovf_h, ovf_l;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Two instances: high-bit-first and low-bit-first priority, same stimulus.
    encoder_4to2_event #(.SYNC_STAGES(SYNC), .HIGH_FIRST(1'b1)) dut_h (
        .clk(clk), .rst(rst), .in(in), .ack(ack),
        .code_out(code_h), .valid(valid_h), .multi(multi_h), .overflow(ovf_h)
    );

    encoder_4to2_event #(.SYNC_STAGES(SYNC), .HIGH_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in(in), .ack(ack),
        .code_out(code_l), .valid(valid_l), .multi(multi_l), .overflow(ovf_l)
    );

    // ---------------- reference model ----------------
    // hist[k] is the input sampled k clock edges ago (hist[0] = this edge).
    // A line's event is recognised SYNC edges after it is sampled high.
    logic [3:0] hist [0:SYNC+1];
    logic [3:0] m_pend [2];
    bit         m_busy [2];
    logic [1:0] m_code [2];
    bit         m_multi [2];
    bit         m_ovf [2];

    function automatic logic [1:0] pick(input logic [3:0] p, input bit hf);
        logic [1:0] r;
        bit found;
        r = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (p[i] && (hf || !found)) begin
                r = i[1:0];
                found = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k <= SYNC + 1; k++) hist[k] = 4'b0000;
        for (int m = 0; m < 2; m++) begin
            m_pend[m]  = 4'b0000;
            m_busy[m]  = 1'b0;
            m_code[m]  = 2'b00;
            m_multi[m] = 1'b0;
            m_ovf[m]   = 1'b0;
        end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input logic [3:0] i_in, input logic i_ack);
        logic [3:0] rise, clr, newp;
        for (int k = SYNC + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = i_in;
        rise = hist[SYNC] & ~hist[SYNC+1];
        for (int m = 0; m < 2; m++) begin
            clr = 4'b0000;
            if (m_busy[m] && i_ack) clr = 4'b0001 << m_code[m];
            m_ovf[m] = |(rise & m_pend[m] & ~clr);
            newp = (m_pend[m] & ~clr) | rise;
            if (m_busy[m]) begin
                if (i_ack) m_busy[m] = 1'b0;
            end else if (m_pend[m] != 4'b0000) begin
                m_code[m] = pick(m_pend[m], (m == 0));
                m_busy[m] = 1'b1;
            end
            m_multi[m] = ($countones(newp) >= 2);
            m_pend[m]  = newp;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_h_code"},  {2'b00, code_h},  {2'b00, m_code[0]});
        check({tag, "_h_valid"}, {3'b000, valid_h}, {3'b000, m_busy[0]});
        check({tag, "_h_multi"}, {3'b000, multi_h}, {3'b000, m_multi[0]});
        check({tag, "_h_ovf"},   {3'b000, ovf_h},   {3'b000, m_ovf[0]});
        check({tag, "_l_code"},  {2'b00, code_l},  {2'b00, m_code[1]});
        check({tag, "_l_valid"}, {3'b000, valid_l}, {3'b000, m_busy[1]});
        check({tag, "_l_multi"}, {3'b000, multi_l}, {3'b000, m_multi[1]});
        check({tag, "_l_ovf"},   {3'b000, ovf_l},   {3'b000, m_ovf[1]});
    endtask

    // ---------------- driver ----------------
    // Drive on the falling edge, let one rising edge happen, sample 1 ns later.
    task automatic tick(input logic [3:0] i_in, input logic i_ack, input string tag);
        @(negedge clk);
        in  = i_in;
        ack = i_ack;
        model_step(i_in, i_ack);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int cnt;
        logic [3:0] r_in;

        model_reset();
        #1;
        check("reset_h_valid", {3'b000, valid_h}, 4'h0);
        check("reset_h_code",  {2'b00, code_h},   4'h0);
        check("reset_h_multi", {3'b000, multi_h}, 4'h0);
        check("reset_h_ovf",   {3'b000, ovf_h},   4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: single 3-cycle pulse on bit 2, ack held high.
        tick(4'b0100, 1'b1, "t1_e1");
        tick(4'b0100, 1'b1, "t1_e2");
        tick(4'b0100, 1'b1, "t1_e3");
        check("t1_no_valid_before_e4", {3'b000, valid_h}, 4'h0);
        tick(4'b0000, 1'b1, "t1_e4");
        check("t1_valid_e4", {3'b000, valid_h}, 4'h1);
        check("t1_code_e4",  {2'b00, code_h},   4'h2);
        tick(4'b0000, 1'b1, "t1_e5");
        check("t1_valid_e5", {3'b000, valid_h}, 4'h0);
        repeat (3) tick(4'b0000, 1'b1, "t1_idle");

        // 2/3: bits 3 and 1 rise together, ack low for 5 cycles.
        repeat (5) tick(4'b1010, 1'b0, "t2_hold");
        check("t2_h_code",  {2'b00, code_h},   4'h3);
        check("t2_h_valid", {3'b000, valid_h}, 4'h1);
        check("t2_h_multi", {3'b000, multi_h}, 4'h1);
        check("t2_l_code",  {2'b00, code_l},   4'h1);
        tick(4'b1010, 1'b1, "t2_ack");
        check("t2_gap_valid", {3'b000, valid_h}, 4'h0);
        tick(4'b1010, 1'b0, "t2_next");
        check("t2_h_code2",  {2'b00, code_h},   4'h1);
        check("t2_h_valid2", {3'b000, valid_h}, 4'h1);
        check("t2_h_multi2", {3'b000, multi_h}, 4'h0);
        repeat (4) tick(4'b0000, 1'b1, "t2_drain");

        // 3: bits 3 and 0 rise together; low-first instance issues 0 then 3.
        repeat (4) tick(4'b1001, 1'b0, "t3_rise");
        check("t3_l_code1", {2'b00, code_l}, 4'h0);
        check("t3_h_code1", {2'b00, code_h}, 4'h3);
        tick(4'b1001, 1'b1, "t3_ack");
        tick(4'b0000, 1'b0, "t3_next");
        check("t3_l_code2",  {2'b00, code_l},   4'h3);
        check("t3_l_valid2", {3'b000, valid_l}, 4'h1);
        repeat (4) tick(4'b0000, 1'b1, "t3_drain");

        // 4: duplicate edge on a pending bit 2 is dropped with one overflow pulse.
        repeat (3) tick(4'b0100, 1'b0, "t4_rise");
        tick(4'b0100, 1'b0, "t4_issue");
        check("t4_code", {2'b00, code_h}, 4'h2);
        repeat (2) tick(4'b0000, 1'b0, "t4_low");
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick(4'b0100, 1'b0, "t4_dup");
            if (ovf_h) cnt++;
        end
        check("t4_ovf_pulses", cnt[3:0], 4'h1);
        tick(4'b0100, 1'b1, "t4_ack");
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick(4'b0100, 1'b1, "t4_after");
            if (valid_h) cnt++;
        end
        check("t4_no_reissue", cnt[3:0], 4'h0);
        repeat (3) tick(4'b0000, 1'b1, "t4_drain");

        // 5: new rise on bit 1 lands on the same edge as its ack.
        tick(4'b0010, 1'b0, "t5_e1");
        tick(4'b0010, 1'b0, "t5_e2");
        tick(4'b0000, 1'b0, "t5_e3");
        tick(4'b0000, 1'b0, "t5_e4");
        check("t5_code", {2'b00, code_h}, 4'h1);
        tick(4'b0010, 1'b0, "t5_e5");
        tick(4'b0010, 1'b0, "t5_e6");
        tick(4'b0000, 1'b1, "t5_e7");
        check("t5_no_ovf",   {3'b000, ovf_h},   4'h0);
        check("t5_gap",      {3'b000, valid_h}, 4'h0);
        tick(4'b0000, 1'b0, "t5_e8");
        check("t5_reissue_valid", {3'b000, valid_h}, 4'h1);
        check("t5_reissue_code",  {2'b00, code_h},   4'h1);
        repeat (3) tick(4'b0000, 1'b1, "t5_drain");

        // 6: asynchronous reset mid-cycle while holding with 3 pending.
        repeat (4) tick(4'b0111, 1'b0, "t6_rise");
        check("t6_pre_valid", {3'b000, valid_h}, 4'h1);
        check("t6_pre_multi", {3'b000, multi_h}, 4'h1);
        check("t6_pre_code",  {2'b00, code_h},   4'h2);
        #2;
        rst = 1'b1;
        in  = 4'b0000;
        #1;
        check("t6_rst_valid", {3'b000, valid_h}, 4'h0);
        check("t6_rst_multi", {3'b000, multi_h}, 4'h0);
        check("t6_rst_code",  {2'b00, code_h},   4'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick(4'b0000, 1'b0, "t6_quiet");
            if (valid_h || valid_l) cnt++;
        end
        check("t6_quiet_valid", cnt[3:0], 4'h0);

        // Random phase: lines toggle occasionally, ack random.
        r_in = 4'b0000;
        for (int k = 0; k < 400; k++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 3) == 0) r_in[b] = ~r_in[b];
            tick(r_in, 1'($urandom_range(0, 1)), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/encoder_4to2_event.md
Name: encoder_4to2_event

Overview:
- Event-capturing 4-to-2 priority encoder, the inverse of the team's 2-to-4 decoder.
- Synchronizes four asynchronous lines (buttons/switches), detects rising edges, and queues each edge as a pending event.
- Issues pending events one at a time as a 2-bit code with a valid/ack handshake to downstream logic, e.g. a decoder-driven LED/display path.

Parameters:
SYNC_STAGES, 2, number of flip-flops in each input synchronizer chain (legal range 2..4).
HIGH_FIRST, 1, 1 = bit 3 has highest priority; 0 = bit 0 has highest priority.

Ports:
clk  input  1  system clock, all state on the rising edge
rst  input  1  asynchronous, active-high reset
in  input  4  asynchronous event lines, one per code
ack  input  1  downstream accepts the current code; sampled on clk edge
code_out  output  2  encoded index of the issued event
valid  output  1  code_out holds an unacknowledged event
multi  output  1  two or more events are pending, including the one being issued
overflow  output  1  one-cycle pulse: an edge arrived on a line whose event was already pending

Behaviour:
- Reset (async, active-high): sync chains, edge-history register, pending[3:0], code_out=2'b00, valid=0, multi=0, overflow=0; state=IDLE. Outputs go to reset values immediately, without waiting for a clock.
- Synchronizer: each in[i] passes through SYNC_STAGES flops; s[i] is the last stage.
- Edge detect: prev[i] <= s[i]; rise[i] = s[i] & ~prev[i]. After reset, a line already high counts as a rise once the sync chain fills.
- Pending register, per bit each edge:
  - set if rise[i];
  - cleared if the bit is the issued one and the event is acknowledged (state HOLD, ack=1);
  - if set and clear happen together, set wins: bit stays 1, no overflow.
- overflow: registered; 1 for exactly one cycle after any edge where rise[i]=1 and pending[i] was already 1 and not being cleared. The duplicate event is dropped.
- multi: registered; equals (popcount of the next pending value >= 2).
- FSM with two states:
  - IDLE: valid=0, code_out holds its last value. If pending!=0, load code_out with the highest-priority set bit per HIGH_FIRST, set valid=1, go to HOLD. ack is ignored in IDLE.
  - HOLD: valid=1, code_out stable. On an edge with ack=1: clear pending[code_out], valid<=0, go to IDLE. With ack=0, stay in HOLD indefinitely while new events keep queueing.
- Throughput: at least one IDLE cycle between issued codes, so one code per 2 cycles maximum. Priority is re-evaluated at each IDLE, so a higher-priority event that arrives during HOLD is issued next.
- Latency: counting the first clk edge that samples in[i]=1 as edge 1, pending[i] is set at edge SYNC_STAGES+1 and valid rises at edge SYNC_STAGES+2, when the FSM is idle with nothing else pending.
- Falling edges and held-high levels generate no events.
- Reset mid-HOLD drops all pending events; no code is issued after reset until a new rise.

Test Plan:
1. Reset with in=0, then pulse in=4'b0100 high for 3 cycles, ack held high → valid rises on edge 4 with code_out=2'b10. valid is high for one cycle, then valid=0 and pending=0.
2. in=4'b1010 rising on the same edge, HIGH_FIRST=1, ack=0 for 5 cycles → code_out=2'b11, valid=1, multi=1 held. Then ack for one cycle → valid=0 for one cycle, then code_out=2'b01, valid=1, multi=0.
3. HIGH_FIRST=0, in=4'b1001 simultaneous rise → first code 2'b00, then 2'b11 after ack.
4. Event on bit 2 pending and unacknowledged, then toggle in[2] low→high again → overflow=1 for exactly one cycle; after one ack, no second 2'b10 issue.
5. In HOLD with code 2'b01, a new rise on bit 1 lands on the same edge as ack → pending[1] stays 1, no overflow; 2'b01 is reissued after the IDLE cycle.
6. Assert rst asynchronously mid-clock while valid=1 with 3 events pending → valid, multi, and code_out go to 0 before the next edge. After release with in=0, valid stays 0 for 20 cycles.
